// File: rtl/image_bram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : image_bram_arbiter
//  Description : Shares the single image BRAM port between a never-stalling
//                camera writer (buffered in a small FIFO) and a read engine.
//  Revision    : 1.0  initial release
// ============================================================================
module image_bram_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int RD_LATENCY   = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_overflow,
    input  logic                          wr_overflow_clr,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_gnt,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          bram_en,
    output logic                          bram_we,
    output logic [ADDR_W-1:0]             bram_addr,
    output logic [DATA_W-1:0]             bram_din,
    input  logic [DATA_W-1:0]             bram_dout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ISSUE_IDLE  = 2'd0,
        ISSUE_WRITE = 2'd1,
        ISSUE_READ  = 2'd2
    } issue_e;

    logic [ADDR_W-1:0]     fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;
    logic [STV_W-1:0]      starve;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic                  hazard;
    logic                  rd_ok;
    logic                  starved;
    issue_e                decision;

    assign full       = (level == DEPTH_LVL);
    assign empty      = (level == '0);
    assign wr_ready   = (level < DEPTH_LVL);
    assign push       = wr_valid && wr_ready;
    assign pop        = (decision == ISSUE_WRITE);
    assign fifo_level = level;
    assign starved    = (starve >= STARVE_MAX);

    // A read must not overtake any buffered write to the same address,
    // including the one entering the FIFO this very cycle.
    always_comb begin
        hazard = push && (wr_addr == rd_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid[i] && (fifo_addr[i] == rd_addr)) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && rd_req;
    end

    // rd_gnt doubles as the grant-pending flag: the held request is ignored
    // during its acceptance cycle.
    assign rd_ok = rd_req && !hazard && !rd_gnt;

    always_comb begin
        decision = ISSUE_IDLE;
        if (full) begin
            decision = ISSUE_WRITE;
        end else if (rd_ok && starved) begin
            decision = ISSUE_READ;
        end else if (!empty) begin
            decision = ISSUE_WRITE;
        end else if (rd_ok) begin
            decision = ISSUE_READ;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            slot_valid <= '0;
        end else begin
            if (push) begin
                wr_ptr             <= wr_ptr + PTR_W'(1);
                slot_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr             <= rd_ptr + PTR_W'(1);
                slot_valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_overflow <= 1'b0;
            starve      <= '0;
        end else begin
            if (wr_valid && !wr_ready) begin
                wr_overflow <= 1'b1;
            end else if (wr_overflow_clr) begin
                wr_overflow <= 1'b0;
            end
            if (!rd_req || rd_gnt || (decision == ISSUE_READ)) begin
                starve <= '0;
            end else if (!starved) begin
                starve <= starve + STV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            rd_gnt    <= 1'b0;
        end else begin
            bram_en <= (decision != ISSUE_IDLE);
            bram_we <= (decision == ISSUE_WRITE);
            rd_gnt  <= (decision == ISSUE_READ);
            if (decision == ISSUE_WRITE) begin
                bram_addr <= fifo_addr[rd_ptr];
                bram_din  <= fifo_data[rd_ptr];
            end else if (decision == ISSUE_READ) begin
                bram_addr <= rd_addr;
            end
        end
    end

    // rd_gnt coincides with the BRAM read cycle; the pipe tracks douta latency.
    generate
        if (RD_LATENCY == 1) begin : g_pipe_single
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_pipe <= '0;
                end else begin
                    rd_pipe <= rd_gnt;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_pipe <= '0;
                end else begin
                    rd_pipe <= {rd_pipe[RD_LATENCY-2:0], rd_gnt};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_pipe[RD_LATENCY-1];
            if (rd_pipe[RD_LATENCY-1]) begin
                rd_data <= bram_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_bram_arbiter.sv
`default_nettype none
// Bench for image_bram_arbiter: directed scenarios plus a random phase, all
// checked each cycle against a queue-based model of the arbitration rules.
module tb_image_bram_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int LIMIT  = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_overflow;
    logic              wr_overflow_clr;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;
    logic [2:0]        fifo_level;

    always #5 clk = ~clk;

    image_bram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT), .RD_LATENCY(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_overflow(wr_overflow),
        .wr_overflow_clr(wr_overflow_clr),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout), .fifo_level(fifo_level)
    );

    // Single-port BRAM, one cycle read latency
    logic [DATA_W-1:0] bram_mem [1 << ADDR_W];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_din;
            else         bram_dout <= bram_mem[bram_addr];
        end
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               q[$];
    logic [DATA_W-1:0] shadow [1 << ADDR_W];
    int                starve;
    bit                gnt_pend;
    bit                s0_v, s1_v;
    logic [DATA_W-1:0] s0_d, s1_d;
    logic              e_en, e_we, e_gnt, e_valid, e_ovf;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_din, e_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_gnt = 0, n_valid = 0;
    int gnt_cyc = 0, valid_cyc = 0;
    int max_level = 0;
    bit drop_pending = 0;
    logic [DATA_W-1:0] last_rd_data;
    logic [ADDR_W-1:0] wlog[$];
    int w_abcd_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        starve = 0; gnt_pend = 0;
        s0_v = 0; s1_v = 0; s0_d = '0; s1_d = '0;
        e_en = 0; e_we = 0; e_gnt = 0; e_valid = 0; e_ovf = 0;
        e_addr = '0; e_din = '0; e_data = '0;
    endtask

    task automatic model_step();
        bit  ready, push, hazard, rd_ok, do_w, do_r;
        wr_t h;
        ready  = (q.size() < DEPTH);
        push   = wr_valid && ready;
        hazard = 0;
        if (rd_req) begin
            foreach (q[i]) if (q[i].a == rd_addr) hazard = 1;
            if (push && wr_addr == rd_addr) hazard = 1;
        end
        rd_ok = rd_req && !hazard && !gnt_pend;
        do_w = 0; do_r = 0;
        if (q.size() == DEPTH)              do_w = 1;
        else if (rd_ok && starve >= LIMIT)  do_r = 1;
        else if (q.size() > 0)              do_w = 1;
        else if (rd_ok)                     do_r = 1;
        e_valid = s1_v;
        if (s1_v) e_data = s1_d;
        s1_v = s0_v; s1_d = s0_d;
        s0_v = do_r; s0_d = shadow[rd_addr];
        if (!rd_req || do_r || gnt_pend) starve = 0;
        else if (starve < LIMIT)         starve++;
        if (wr_valid && !ready)   e_ovf = 1;
        else if (wr_overflow_clr) e_ovf = 0;
        e_en = do_w || do_r;
        e_we = do_w;
        if (do_w) begin
            h = q.pop_front();
            e_addr = h.a; e_din = h.d;
            shadow[h.a] = h.d;
        end else if (do_r) begin
            e_addr = rd_addr;
        end
        if (push) q.push_back({wr_addr, wr_data});
        e_gnt = do_r;
        gnt_pend = do_r;
    endtask

    task automatic compare_all();
        check("wr_ready",    wr_ready,    32'(q.size() < DEPTH));
        check("fifo_level",  fifo_level,  q.size());
        check("wr_overflow", wr_overflow, e_ovf);
        check("bram_en",     bram_en,     e_en);
        check("bram_we",     bram_we,     e_we);
        check("bram_addr",   bram_addr,   e_addr);
        check("bram_din",    bram_din,    e_din);
        check("rd_gnt",      rd_gnt,      e_gnt);
        check("rd_valid",    rd_valid,    e_valid);
        check("rd_data",     rd_data,     e_data);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        if (bram_en && bram_we) begin
            wlog.push_back(bram_addr);
            if (bram_addr == 10'd9 && bram_din == 16'hABCD) w_abcd_cyc = cyc;
        end
        if (rd_gnt)   begin n_gnt++;   gnt_cyc = cyc; end
        if (rd_valid) begin n_valid++; valid_cyc = cyc; last_rd_data = rd_data; end
        if (drop_pending) begin rd_req = 0; drop_pending = 0; end
        if (rd_gnt) drop_pending = 1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        wr_valid = 0; wr_overflow_clr = 0; rd_req = 0; drop_pending = 0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    initial begin
        int base, req_start, gnt_delay, seen;
        bit overflowed;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            bram_mem[i] = '0;
            shadow[i]   = '0;
        end
        bram_dout = '0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        last_rd_data = '0;
        do_reset();

        // Three back-to-back writes
        max_level = 0;
        wlog.delete();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_addr = 10'(5 + i); wr_data = 16'(16'h1111 * (i + 1));
            tick();
        end
        wr_valid = 0;
        repeat (3) tick();
        check("s1_peak_level", max_level, 1);
        check("s1_wlog_size", wlog.size(), 3);
        if (wlog.size() == 3) begin
            check("s1_w0", wlog[0], 5);
            check("s1_w1", wlog[1], 6);
            check("s1_w2", wlog[2], 7);
        end
        check("s1_overflow", wr_overflow, 0);

        // Read back address 6
        base = n_valid;
        rd_req = 1; rd_addr = 10'd6;
        for (int i = 0; i < 20 && n_valid == base; i++) tick();
        check("s2_valid_seen", n_valid - base, 1);
        check("s2_rd_data", last_rd_data, 16'h2222);
        check("s2_latency", valid_cyc - gnt_cyc, 2);
        repeat (2) tick();

        // Continuous writes with a competing read
        max_level = 0;
        base = n_gnt;
        req_start = -1;
        gnt_delay = -1;
        for (int i = 0; i < 40; i++) begin
            wr_valid = 1; wr_addr = 10'(200 + i); wr_data = 16'($urandom);
            if (i == 2) begin rd_req = 1; rd_addr = 10'd100; req_start = cyc; end
            tick();
            if (rd_gnt && gnt_delay < 0) gnt_delay = cyc - req_start;
        end
        wr_valid = 0;
        repeat (6) tick();
        check("s3_granted", n_gnt - base, 1);
        check("s3_gnt_in_time", 32'(gnt_delay >= 1 && gnt_delay <= LIMIT + 1), 1);
        check("s3_level_le4", 32'(max_level <= DEPTH), 1);
        check("s3_overflow", wr_overflow, 0);

        // Read right after a write to the same address
        wr_valid = 1; wr_addr = 10'd9; wr_data = 16'h0BAD; tick();
        wr_valid = 0; repeat (3) tick();
        w_abcd_cyc = -1;
        base = n_valid;
        wr_valid = 1; wr_addr = 10'd9; wr_data = 16'hABCD; tick();
        wr_valid = 0; rd_req = 1; rd_addr = 10'd9;
        for (int i = 0; i < 20 && n_valid == base; i++) tick();
        check("s4_valid_seen", n_valid - base, 1);
        check("s4_gnt_after_write", 32'(w_abcd_cyc > 0 && gnt_cyc > w_abcd_cyc), 1);
        check("s4_rd_data", last_rd_data, 16'hABCD);
        repeat (3) tick();

        // Starved reads stall the drain until overflow
        max_level = 0;
        overflowed = 0;
        for (int i = 0; i < 150 && !overflowed; i++) begin
            wr_valid = 1; wr_addr = 10'(300 + (i % 100)); wr_data = 16'($urandom);
            if (!rd_req) begin rd_req = 1; rd_addr = 10'(50 + (i % 40)); end
            tick();
            overflowed = wr_overflow;
        end
        check("s5_overflow_set", wr_overflow, 1);
        check("s5_reached_full", max_level, DEPTH);
        wr_valid = 0; rd_req = 0; drop_pending = 0; wr_overflow_clr = 1;
        tick();
        wr_overflow_clr = 0;
        check("s5_overflow_clr", wr_overflow, 0);
        repeat (8) tick();

        // Reset one cycle after a grant
        seen = 0;
        rd_req = 1; rd_addr = 10'd5;
        for (int i = 0; i < 20 && !rd_gnt; i++) tick();
        check("s6_gnt_seen", rd_gnt, 1);
        tick();
        base = n_valid;
        reset_n = 0;
        rd_req = 0; drop_pending = 0;
        #1;
        model_reset();
        check("s6_rst_level", fifo_level, 0);
        check("s6_rst_ready", wr_ready, 1);
        check("s6_rst_bram_en", bram_en, 0);
        check("s6_rst_bram_addr", bram_addr, 0);
        check("s6_rst_rd_valid", rd_valid, 0);
        check("s6_rst_rd_data", rd_data, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        repeat (5) tick();
        check("s6_no_valid", n_valid - base, 0);

        // Random traffic with hazards on a small address range
        for (int i = 0; i < 400; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 10'($urandom_range(0, 15));
            wr_data  = 16'($urandom);
            wr_overflow_clr = ($urandom_range(0, 19) == 0);
            if (!rd_req && $urandom_range(0, 2) == 0) begin
                rd_req = 1; rd_addr = 10'($urandom_range(0, 15));
            end
            tick();
        end
        wr_valid = 0; wr_overflow_clr = 0;
        repeat (30) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
